// File: rtl/ov7670_capture.sv
// OV7670 byte-stream capture: registers VSYNC/HREF/D, packs byte pairs into RGB444
// pixels and writes them into the 320x240 frame buffer, reporting frame completion and overrun.
module ov7670_capture #(
    parameter int ADDR_W     = 17,
    parameter int PIX_W      = 12,
    parameter int MAX_PIXELS = 76800
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] wraddress,
    output logic [PIX_W-1:0]  data,
    output logic              wren,
    output logic              frame_done,
    output logic [ADDR_W-1:0] frame_pixels,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(MAX_PIXELS);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

    state_t            state_q, state_d;
    logic              vs_r, hr_r;
    logic [7:0]        d_r;
    logic              phase;
    logic [3:0]        red;
    logic [ADDR_W-1:0] index, idx_nxt;
    logic              do_write, frame_end;

    // Write port: wren is a single-cycle strobe per pixel; wraddress/data are
    // meaningful only while wren=1 and simply hold their last value otherwise.
    always_comb begin
        state_d   = state_q;
        do_write  = 1'b0;
        frame_end = 1'b0;
        idx_nxt   = index;
        case (state_q)
            IDLE:   if (vs_r) state_d = SYNC;
            SYNC:   if (!vs_r) state_d = ACTIVE;
            ACTIVE: begin
                if (hr_r && phase && index < MAX_IDX) begin
                    do_write = 1'b1;
                    idx_nxt  = index + 1'b1;
                end
                // A byte pair completing together with the vsync rise is still written.
                if (vs_r) begin
                    state_d   = SYNC;
                    frame_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r    <= 1'b0;
            hr_r    <= 1'b0;
            d_r     <= '0;
            state_q <= IDLE;
        end else begin
            vs_r    <= vsync;
            hr_r    <= href;
            d_r     <= d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= 1'b0;
            red          <= '0;
            index        <= '0;
            wraddress    <= '0;
            data         <= '0;
            wren         <= 1'b0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            overflow     <= 1'b0;
        end else begin
            wren       <= do_write;
            frame_done <= frame_end;
            if (state_q == SYNC) begin
                index    <= '0;
                phase    <= 1'b0;
                overflow <= 1'b0;
            end else if (state_q == ACTIVE) begin
                // HREF low ends the line; a dangling odd byte is dropped.
                if (!hr_r) begin
                    phase <= 1'b0;
                end else if (!phase) begin
                    red   <= d_r[3:0];
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    index <= idx_nxt;
                    if (do_write) begin
                        data      <= {red, d_r};
                        wraddress <= index;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                if (frame_end) frame_pixels <= idx_nxt;
            end
        end
    end

endmodule
